stage_2: RTL and testbench

Second stage of the ASP datapath; consumes the registered opcode, data-plus-parity (DPP) and network-data-plus-tag (NDT) words produced by `stage_1`. It checks DPP parity and captures good data, matches NDT tags against the local node tag, and queues outbound NDT words in a small FIFO drained over a valid/ready link to the network. `stage_1` has no stall path, so this stage never back-pressures it. It drops and counts on overflow instead.

---
 rtl/asp_pkg.sv | 19 +
 rtl/stage_2_fifo.sv | 56 +++++
 rtl/stage_2.sv | 111 +++++++++++
 tb/tb_stage_2.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asp_pkg.sv
// Shared ASP datapath definitions: opcodes, counter width
// and the saturating-increment helper.
package asp_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MATCH = 2'b10;
  localparam logic [1:0] OP_SEND  = 2'b11;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/stage_2_fifo.sv
// Outbound NDT FIFO: wrapping pointers, occupancy count,
// head word presented directly from storage (no bypass).
module stage_2_fifo #(
  parameter int width = 40,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             ready,
  output logic [width-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             do_push;

  assign valid   = count != '0;
  assign full    = count == CW'(depth);
  assign pop     = valid && ready;
  // a full FIFO still accepts when the head leaves this cycle
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stage_2.sv
// ASP stage 2: parity check, tag match, outbound FIFO.
// STAGE_2_ERR_CNT_EN enables the error/overflow counters.
module stage_2
  import asp_pkg::*;
#(
  parameter int data_size  = 32,
  parameter int tag_size   = 8,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    opcode_in,
  input  logic [data_size:0]            dpp_in,
  input  logic [data_size+tag_size-1:0] ndt_in,
  input  logic [tag_size-1:0]           local_tag,
  output logic [data_size-1:0]          data_out,
  output logic                          data_valid,
  output logic                          match_hit,
  output logic                          parity_err,
  output logic [CNT_W-1:0]              err_count,
  output logic [CNT_W-1:0]              ovf_count,
  output logic [data_size+tag_size-1:0] net_data,
  output logic                          net_valid,
  input  logic                          net_ready
);

  localparam int NW = data_size + tag_size;

  logic is_store;
  logic is_match;
  logic is_send;
  logic par_bad;
  logic tag_eq;
  logic st_ok;
  logic st_bad;
  logic mt_hit;
  logic pop;
  logic full;

  assign is_store = opcode_in == OP_STORE;
  assign is_match = opcode_in == OP_MATCH;
  assign is_send  = opcode_in == OP_SEND;
  // even parity: all data_size+1 bits must XOR to zero
  assign par_bad  = ^dpp_in;
  assign tag_eq   = ndt_in[NW-1 -: tag_size] == local_tag;
  assign st_ok    = is_store && !par_bad;
  assign st_bad   = is_store && par_bad;
  assign mt_hit   = is_match && tag_eq;
  assign pop      = net_valid && net_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      match_hit  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      match_hit  <= 1'b0;
      unique case (1'b1)
        st_ok: begin
          data_out   <= dpp_in[data_size-1:0];
          data_valid <= 1'b1;
        end
        st_bad: parity_err <= 1'b1;
        mt_hit: begin
          data_out   <= ndt_in[data_size-1:0];
          data_valid <= 1'b1;
          match_hit  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STAGE_2_ERR_CNT_EN
  logic drop;

  assign drop = is_send && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
      ovf_count <= '0;
    end else begin
      if (st_bad)
        err_count <= sat_inc(err_count);
      if (drop)
        ovf_count <= sat_inc(ovf_count);
    end
  end
`else
  assign err_count = '0;
  assign ovf_count = '0;
`endif

  stage_2_fifo #(
    .width (NW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (is_send),
    .wdata (ndt_in),
    .ready (net_ready),
    .rdata (net_data),
    .valid (net_valid),
    .full  (full)
  );

endmodule

// File: tb/tb_stage_2.sv
// Self-checking bench for stage_2: directed cases plus
// randomized traffic against a queue-based reference model.
module tb_stage_2;
  import asp_pkg::*;

  localparam int DS    = 32;
  localparam int TS    = 8;
  localparam int DEPTH = 4;
  localparam int NW    = DS + TS;
`ifdef STAGE_2_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    opcode_in;
  logic [DS:0]   dpp_in;
  logic [NW-1:0] ndt_in;
  logic [TS-1:0] local_tag;
  logic [DS-1:0] data_out;
  logic          data_valid;
  logic          match_hit;
  logic          parity_err;
  logic [7:0]    err_count;
  logic [7:0]    ovf_count;
  logic [NW-1:0] net_data;
  logic          net_valid;
  logic          net_ready;

  stage_2 #(
    .data_size  (DS),
    .tag_size   (TS),
    .fifo_depth (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode_in  (opcode_in),
    .dpp_in     (dpp_in),
    .ndt_in     (ndt_in),
    .local_tag  (local_tag),
    .data_out   (data_out),
    .data_valid (data_valid),
    .match_hit  (match_hit),
    .parity_err (parity_err),
    .err_count  (err_count),
    .ovf_count  (ovf_count),
    .net_data   (net_data),
    .net_valid  (net_valid),
    .net_ready  (net_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [DS-1:0] m_data;
  bit            m_dv;
  bit            m_hit;
  bit            m_perr;
  int            m_err;
  int            m_ovf;
  logic [NW-1:0] q[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_dv   = 0;
    m_hit  = 0;
    m_perr = 0;
    m_err  = 0;
    m_ovf  = 0;
    q.delete();
  endtask

  // applies one clock edge using the inputs held across it
  task automatic model_step();
    bit pop;
    pop   = (q.size() != 0) && net_ready;
    m_dv  = 0;
    m_hit = 0;
    case (opcode_in)
      OP_STORE: begin
        if ((^dpp_in) == 1'b0) begin
          m_data = dpp_in[DS-1:0];
          m_dv   = 1;
        end else begin
          m_perr = 1;
          if (m_err < 255) m_err++;
        end
      end
      OP_MATCH: begin
        if (ndt_in[NW-1:DS] == local_tag) begin
          m_data = ndt_in[DS-1:0];
          m_dv   = 1;
          m_hit  = 1;
        end
      end
      default: ;
    endcase
    if (pop) void'(q.pop_front());
    if (opcode_in == OP_SEND) begin
      if (q.size() < DEPTH) q.push_back(ndt_in);
      else if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic check_all();
    chk("data_out", 64'(data_out), 64'(m_data));
    chk("data_valid", 64'(data_valid), 64'(m_dv));
    chk("match_hit", 64'(match_hit), 64'(m_hit));
    chk("parity_err", 64'(parity_err), 64'(m_perr));
    chk("err_count", 64'(err_count), CNT_EN ? 64'(m_err) : 64'd0);
    chk("ovf_count", 64'(ovf_count), CNT_EN ? 64'(m_ovf) : 64'd0);
    chk("net_valid", 64'(net_valid), 64'(q.size() != 0));
    if (q.size() != 0)
      chk("net_data", 64'(net_data), 64'(q[0]));
  endtask

  task automatic cycle(
    input logic [1:0]    op,
    input logic [DS:0]   dpp,
    input logic [NW-1:0] ndt,
    input logic          rdy
  );
    opcode_in = op;
    dpp_in    = dpp;
    ndt_in    = ndt;
    net_ready = rdy;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_data_out"}, 64'(data_out), 64'd0);
    chk({nm, "_data_valid"}, 64'(data_valid), 64'd0);
    chk({nm, "_match_hit"}, 64'(match_hit), 64'd0);
    chk({nm, "_parity_err"}, 64'(parity_err), 64'd0);
    chk({nm, "_err_count"}, 64'(err_count), 64'd0);
    chk({nm, "_ovf_count"}, 64'(ovf_count), 64'd0);
    chk({nm, "_net_valid"}, 64'(net_valid), 64'd0);
    chk({nm, "_net_data"}, 64'(net_data), 64'd0);
  endtask

  function automatic logic [NW-1:0] mk(logic [TS-1:0] t, logic [DS-1:0] d);
    return {t, d};
  endfunction

  initial begin
    logic [DS-1:0] d;
    logic [TS-1:0] t;
    logic [1:0]    op;
    bit            bad;
    int            ec;
    int            oc;

    reset     = 1'b1;
    opcode_in = OP_NOP;
    dpp_in    = '0;
    ndt_in    = '0;
    local_tag = 8'hA5;
    net_ready = 1'b0;
    model_reset();
    #2;
    chk_zero("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // parity store
    cycle(OP_STORE, {1'b0, 32'h0000_0003}, '0, 1'b0);
    chk("st_good_data", 64'(data_out), 64'd3);
    chk("st_good_dv", 64'(data_valid), 64'd1);
    cycle(OP_NOP, '0, '0, 1'b0);
    chk("dv_pulse_end", 64'(data_valid), 64'd0);
    cycle(OP_STORE, {1'b1, 32'h0000_0003}, '0, 1'b0);
    chk("st_bad_data", 64'(data_out), 64'd3);
    chk("st_bad_perr", 64'(parity_err), 64'd1);
    chk("st_bad_ec", 64'(err_count), CNT_EN ? 64'd1 : 64'd0);

    // tag match
    cycle(OP_MATCH, '0, mk(8'hA5, 32'hDEAD_BEEF), 1'b0);
    chk("mt_data", 64'(data_out), 64'hDEAD_BEEF);
    chk("mt_hit", 64'(match_hit), 64'd1);
    cycle(OP_MATCH, '0, mk(8'hA4, 32'h1234_5678), 1'b0);
    chk("mt_miss_hit", 64'(match_hit), 64'd0);
    chk("mt_miss_data", 64'(data_out), 64'hDEAD_BEEF);

    // fill past capacity, then drain in order
    for (int i = 1; i <= 5; i++)
      cycle(OP_SEND, '0, mk(8'h11, 32'(i)), 1'b0);
    chk("ovf_one", 64'(ovf_count), CNT_EN ? 64'd1 : 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), 64'(net_data[DS-1:0]), 64'(i));
      cycle(OP_NOP, '0, '0, 1'b1);
    end
    chk("drained_empty", 64'(net_valid), 64'd0);

    // full FIFO, pop and push in the same cycle
    for (int i = 1; i <= 4; i++)
      cycle(OP_SEND, '0, mk(8'h22, 32'(16 + i)), 1'b0);
    cycle(OP_SEND, '0, mk(8'h22, 32'd99), 1'b1);
    chk("full_pp_ovf", 64'(ovf_count), CNT_EN ? 64'd1 : 64'd0);
    chk("full_pp_head", 64'(net_data[DS-1:0]), 64'd18);
    for (int i = 0; i < 3; i++)
      cycle(OP_NOP, '0, '0, 1'b1);
    chk("full_pp_last", 64'(net_data[DS-1:0]), 64'd99);
    cycle(OP_NOP, '0, '0, 1'b1);

    // asynchronous reset with two words queued
    cycle(OP_SEND, '0, mk(8'h33, 32'hA), 1'b0);
    cycle(OP_SEND, '0, mk(8'h33, 32'hB), 1'b0);
    chk("pre_rst_valid", 64'(net_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(OP_NOP, '0, '0, 1'b0);
    chk("post_rst_valid", 64'(net_valid), 64'd0);

    // error counter saturation
    for (int i = 0; i < 300; i++)
      cycle(OP_STORE, {1'b1, 32'h0}, '0, 1'b0);
    chk("ec_sat", 64'(err_count), CNT_EN ? 64'd255 : 64'd0);

    // randomized traffic with varying backpressure
    for (int i = 0; i < 3000; i++) begin
      op  = 2'($urandom_range(0, 3));
      d   = $urandom();
      bad = $urandom_range(0, 3) == 0;
      t   = $urandom_range(0, 1) ? local_tag : 8'($urandom());
      cycle(op, {(^d) ^ bad, d}, mk(t, d),
            ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 3) != 0));
    end

    // long overflow run: ovf_count saturates
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 262; i++)
      cycle(OP_SEND, '0, mk(8'h44, 32'(i)), 1'b0);
    ec = CNT_EN ? 255 : 0;
    oc = 64'(ovf_count);
    chk("ovf_sat", 64'(oc), 64'(ec));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
